// File: rtl/uart_loopback_ctrl.sv
// UART loopback controller: moves received bytes into a shared FIFO and
// drains that FIFO into the transmitter one byte at a time.
module uart_loopback_ctrl #(
  parameter int FIFO_RD_LAT = 1,
  parameter int TX_GAP      = 0,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_rx_byte_rdy,
  input  logic [7:0]       i_rx_byte,
  input  logic             i_fifo_full,
  input  logic             i_fifo_empty,
  input  logic [7:0]       i_fifo_q,
  output logic             o_fifo_wrreq,
  output logic [7:0]       o_fifo_data,
  output logic             o_fifo_rdreq,
  input  logic             i_tx_done,
  output logic [7:0]       o_tx_byte,
  output logic             o_tx_byte_rdy,
  input  logic             i_ovf_clr,
  output logic [CNT_W-1:0] o_ovf_cnt,
  output logic             o_ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_BUSY,
    S_GAP
  } state_t;

  // Counters run up from 0 while their state is active; these are the
  // values seen in the final cycle of WAIT and GAP respectively.
  localparam logic [1:0] LAT_LAST = 2'(FIFO_RD_LAT - 1);
  localparam logic [7:0] GAP_LAST = 8'((TX_GAP > 0) ? TX_GAP - 1 : 0);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] lat_cnt;
  logic [7:0] gap_cnt;
  logic       wr_ok;
  logic       rx_drop;

  assign wr_ok   = i_rx_byte_rdy && !i_fifo_full;
  assign rx_drop = i_rx_byte_rdy && i_fifo_full;

  // ---------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------
  // NOTE: every register below uses <= so all flops update together from
  // pre-edge values; a blocking = here would create order-dependent logic.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fifo_wrreq <= 1'b0;
      o_fifo_data  <= 8'h00;
    end else begin
      o_fifo_wrreq <= wr_ok;
      if (wr_ok) o_fifo_data <= i_rx_byte;
    end
  end

  // Clear wins over a same-cycle drop; the count sticks at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf_cnt <= '0;
      o_ovf     <= 1'b0;
    end else if (i_ovf_clr) begin
      o_ovf_cnt <= '0;
      o_ovf     <= 1'b0;
    end else if (rx_drop) begin
      o_ovf <= 1'b1;
      if (o_ovf_cnt != '1) o_ovf_cnt <= o_ovf_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Read side FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt is given a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (i_en && !i_fifo_empty) state_nxt = S_READ;
      S_READ: state_nxt = S_WAIT;
      S_WAIT: if (lat_cnt == LAT_LAST) state_nxt = S_SEND;
      S_SEND: state_nxt = S_BUSY;
      S_BUSY: if (i_tx_done) state_nxt = (TX_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:  if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lat_cnt <= 2'd0;
      gap_cnt <= 8'd0;
    end else begin
      lat_cnt <= (state == S_WAIT) ? lat_cnt + 2'd1 : 2'd0;
      gap_cnt <= (state == S_GAP)  ? gap_cnt + 8'd1 : 8'd0;
    end
  end

  // Pulses are decoded from the next state so they are flop outputs that
  // coincide exactly with the READ and SEND cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fifo_rdreq  <= 1'b0;
      o_tx_byte_rdy <= 1'b0;
      o_tx_byte     <= 8'h00;
    end else begin
      o_fifo_rdreq  <= (state_nxt == S_READ);
      o_tx_byte_rdy <= (state_nxt == S_SEND);
      if (state == S_WAIT && lat_cnt == LAT_LAST) o_tx_byte <= i_fifo_q;
    end
  end

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Directed bench for uart_loopback_ctrl: two instances (read latency 1 with
// no gap, read latency 3 with a 4-cycle gap), each fed by a small FIFO model.
module tb_uart_loopback_ctrl;

  localparam int GAP_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- instance A: FIFO_RD_LAT=1, TX_GAP=0 ----------------
  logic       a_en = 0, a_rx_rdy = 0, a_full_force = 0, a_tx_done = 0, a_ovf_clr = 0;
  logic [7:0] a_rx_byte = 0;
  logic       a_full, a_empty, a_wrreq, a_rdreq, a_tx_rdy, a_ovf;
  logic [7:0] a_q = 0, a_data, a_tx_byte, a_ovf_cnt;

  uart_loopback_ctrl #(.FIFO_RD_LAT(1), .TX_GAP(0), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(a_en),
    .i_rx_byte_rdy(a_rx_rdy), .i_rx_byte(a_rx_byte),
    .i_fifo_full(a_full), .i_fifo_empty(a_empty), .i_fifo_q(a_q),
    .o_fifo_wrreq(a_wrreq), .o_fifo_data(a_data), .o_fifo_rdreq(a_rdreq),
    .i_tx_done(a_tx_done), .o_tx_byte(a_tx_byte), .o_tx_byte_rdy(a_tx_rdy),
    .i_ovf_clr(a_ovf_clr), .o_ovf_cnt(a_ovf_cnt), .o_ovf(a_ovf)
  );

  logic [7:0] a_mem [0:15];
  int a_wp = 0, a_rp = 0, a_cnt = 0;
  always @(posedge clk) begin
    if (a_wrreq) begin a_mem[a_wp[3:0]] <= a_data; a_wp <= a_wp + 1; end
    if (a_rdreq) begin a_q <= a_mem[a_rp[3:0]]; a_rp <= a_rp + 1; end
    a_cnt <= a_cnt + (a_wrreq ? 1 : 0) - (a_rdreq ? 1 : 0);
  end
  assign a_empty = (a_cnt == 0);
  assign a_full  = a_full_force || (a_cnt >= 16);

  // ---------------- instance B: FIFO_RD_LAT=3, TX_GAP=4 ----------------
  logic       b_en = 0, b_rx_rdy = 0, b_tx_done = 0, b_ovf_clr = 0;
  logic [7:0] b_rx_byte = 0;
  logic       b_full, b_empty, b_wrreq, b_rdreq, b_tx_rdy, b_ovf;
  logic [7:0] b_q = 0, b_data, b_tx_byte, b_ovf_cnt;

  uart_loopback_ctrl #(.FIFO_RD_LAT(3), .TX_GAP(GAP_B), .CNT_W(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(b_en),
    .i_rx_byte_rdy(b_rx_rdy), .i_rx_byte(b_rx_byte),
    .i_fifo_full(b_full), .i_fifo_empty(b_empty), .i_fifo_q(b_q),
    .o_fifo_wrreq(b_wrreq), .o_fifo_data(b_data), .o_fifo_rdreq(b_rdreq),
    .i_tx_done(b_tx_done), .o_tx_byte(b_tx_byte), .o_tx_byte_rdy(b_tx_rdy),
    .i_ovf_clr(b_ovf_clr), .o_ovf_cnt(b_ovf_cnt), .o_ovf(b_ovf)
  );

  // Read data shows junk (EE, then DD) until 3 edges after the pop.
  logic [7:0] b_mem [0:15];
  int b_wp = 0, b_rp = 0, b_cnt = 0, b_age = 0;
  always @(posedge clk) begin
    if (b_wrreq) begin b_mem[b_wp[3:0]] <= b_data; b_wp <= b_wp + 1; end
    b_cnt <= b_cnt + (b_wrreq ? 1 : 0) - (b_rdreq ? 1 : 0);
    if (b_rdreq) begin
      b_q <= 8'hEE; b_age <= 1;
    end else if (b_age == 1) begin
      b_q <= 8'hDD; b_age <= 2;
    end else if (b_age == 2) begin
      b_q <= b_mem[b_rp[3:0]]; b_rp <= b_rp + 1; b_age <= 0;
    end
  end
  assign b_empty = (b_cnt == 0);
  assign b_full  = (b_cnt >= 16);

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_push(input logic [7:0] d);
    a_rx_rdy = 1'b1; a_rx_byte = d;
    tick();
    a_rx_rdy = 1'b0;
  endtask

  task automatic b_push(input logic [7:0] d);
    b_rx_rdy = 1'b1; b_rx_byte = d;
    tick();
    b_rx_rdy = 1'b0;
  endtask

  task automatic a_wait_rdy(input string nm);
    int n;
    n = 0;
    while (!a_tx_rdy && n < 40) begin tick(); n++; end
    check({nm, "_rdy_seen"}, a_tx_rdy, 1'b1);
  endtask

  task automatic a_done();
    a_tx_done = 1'b1;
    tick();
    a_tx_done = 1'b0;
  endtask

  typedef struct {
    logic       rx_rdy;
    logic [7:0] rx_byte;
    logic       tx_done;
    logic       exp_wrreq;
    logic [7:0] exp_data;
    logic       exp_rdreq;
    logic       exp_rdy;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, m;
    logic saw;

    // Single byte through instance A, cycle by cycle; tx_done pulses in
    // READ and SEND must be ignored.
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5};

    // Reset state
    tick(); tick();
    check("reset_a", {a_wrreq, a_data, a_rdreq, a_tx_byte, a_tx_rdy, a_ovf_cnt, a_ovf}, '0);
    check("reset_b", {b_wrreq, b_data, b_rdreq, b_tx_byte, b_tx_rdy, b_ovf_cnt, b_ovf}, '0);
    rst = 1'b0; a_en = 1'b1; b_en = 1'b1;
    tick(); tick();

    for (int i = 0; i < 9; i++) begin
      a_rx_rdy = vecs[i].rx_rdy; a_rx_byte = vecs[i].rx_byte; a_tx_done = vecs[i].tx_done;
      tick();
      check($sformatf("single_row%0d", i),
            {a_wrreq, a_data, a_rdreq, a_tx_rdy, a_tx_byte},
            {vecs[i].exp_wrreq, vecs[i].exp_data, vecs[i].exp_rdreq, vecs[i].exp_rdy, vecs[i].exp_tx});
    end
    a_rx_rdy = 1'b0; a_tx_done = 1'b0;

    // Drain 3 bytes through instance B (read latency 3, gap 4)
    b_push(8'h01); b_push(8'h02); b_push(8'h03);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      while (!b_rdreq && n < 60) begin tick(); n++; end
      check($sformatf("drain%0d_rdreq", i), b_rdreq, 1'b1);
      // After done: GAP_B gap cycles, one IDLE cycle, then READ
      if (i > 0) check($sformatf("drain%0d_gap", i), n, GAP_B + 2);
      m = 0;
      while (!b_tx_rdy && m < 20) begin tick(); m++; end
      check($sformatf("drain%0d_lat", i), m, 4);
      check($sformatf("drain%0d_byte", i), b_tx_byte, i + 1);
      repeat (10) tick();
      b_tx_done = 1'b1;
      tick();
      b_tx_done = 1'b0;
      n = 1;
    end
    saw = 1'b0;
    repeat (12) begin tick(); if (b_rdreq) saw = 1'b1; end
    check("drain_empty_no_rdreq", saw, 1'b0);

    // Overflow saturation on instance A
    a_full_force = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a_rx_rdy = 1'b1; a_rx_byte = i[7:0];
      tick();
      if (a_wrreq) saw = 1'b1;
      if (i == 0)   check("ovf_first", {a_ovf, a_ovf_cnt}, {1'b1, 8'd1});
      if (i == 253) check("ovf_254", a_ovf_cnt, 8'd254);
    end
    check("ovf_no_wrreq", saw, 1'b0);
    check("ovf_saturated", {a_ovf, a_ovf_cnt}, {1'b1, 8'd255});
    a_ovf_clr = 1'b1;
    tick();
    a_ovf_clr = 1'b0; a_rx_rdy = 1'b0;
    check("ovf_clear_priority", {a_ovf, a_ovf_cnt}, 9'd0);
    a_full_force = 1'b0;
    tick();

    // i_en dropped during BUSY with two bytes queued
    a_push(8'h11); a_push(8'h22); a_push(8'h33);
    a_wait_rdy("en_b0");
    check("en_b0_byte", a_tx_byte, 8'h11);
    tick();
    a_en = 1'b0;
    a_done();
    saw = 1'b0;
    repeat (20) begin tick(); if (a_rdreq || a_tx_rdy) saw = 1'b1; end
    check("en_parked", saw, 1'b0);
    a_en = 1'b1;
    tick();
    check("en_resume_rdreq", a_rdreq, 1'b1);
    a_wait_rdy("en_b1");
    check("en_b1_byte", a_tx_byte, 8'h22);
    tick(); a_done();
    a_wait_rdy("en_b2");
    check("en_b2_byte", a_tx_byte, 8'h33);
    tick(); a_done();
    tick();

    // Asynchronous reset while in WAIT
    a_full_force = 1'b1; a_rx_rdy = 1'b1; a_rx_byte = 8'h99;
    tick();
    a_full_force = 1'b0; a_rx_rdy = 1'b0;
    a_push(8'h5A);
    n = 0;
    while (!a_rdreq && n < 10) begin tick(); n++; end
    check("rst_pre_rdreq", a_rdreq, 1'b1);
    tick();
    #1 rst = 1'b1;
    #1;
    check("rst_async_outputs",
          {a_wrreq, a_data, a_rdreq, a_tx_byte, a_tx_rdy, a_ovf_cnt, a_ovf}, '0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin tick(); if (a_rdreq || a_tx_rdy) saw = 1'b1; end
    check("rst_no_resume", saw, 1'b0);
    a_push(8'hC3);
    a_wait_rdy("rst_next");
    check("rst_next_byte", a_tx_byte, 8'hC3);
    tick(); a_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
